// File: rtl/decred_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decred_collector_pkg
// Description : Shared types and sizing helpers for the hash result collector.
// Revision    : 1.0 - initial release
// ============================================================================
package decred_collector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CAPT = 2'd2,
        PUSH = 2'd3
    } state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int DEF_NUM_MACROS   = 4;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_RESULT_BYTES = 4;
    localparam int RESULT_W         = DEF_DATA_W * DEF_RESULT_BYTES;
    localparam int ID_W             = clog2_min1(DEF_NUM_MACROS);

endpackage
`default_nettype wire

// File: rtl/decred_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : decred_result_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module decred_result_fifo
    import decred_collector_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_wr_en && !w_full;
    assign w_pop   = i_rd_en && !w_empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_valid   = !w_empty;
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/decred_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : decred_result_collector
// Description : Round-robin byte-serial readback of hash macro results into a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module decred_result_collector
    import decred_collector_pkg::*;
#(
    parameter int                NUM_MACROS       = 4,
    parameter int                DATA_W           = 8,
    parameter int                ADDR_W           = 6,
    parameter int                RESULT_BYTES     = 4,
    parameter logic [ADDR_W-1:0] RESULT_BASE_ADDR = 6'h38,
    parameter int                RD_LATENCY       = 1,
    parameter int                FIFO_DEPTH       = 8
) (
    input  logic                                CLK,
    input  logic                                RESET_N,
    input  logic                                ENABLE,
    input  logic [NUM_MACROS-1:0]               DATA_AVAILABLE,
    output logic [NUM_MACROS-1:0]               MACRO_RD_SELECT,
    output logic [ADDR_W-1:0]                   HASH_ADDR,
    input  logic [DATA_W-1:0]                   DATA_FROM_HASH,
    output logic                                RES_VALID,
    input  logic                                RES_READY,
    output logic [DATA_W*RESULT_BYTES-1:0]      RES_DATA,
    output logic [clog2_min1(NUM_MACROS)-1:0]   RES_MACRO_ID,
    output logic [$clog2(FIFO_DEPTH):0]         FIFO_COUNT,
    output logic                                IRQ_OUT
);

    localparam int c_result_w = DATA_W * RESULT_BYTES;
    localparam int c_id_w     = clog2_min1(NUM_MACROS);
    localparam int c_bidx_w   = clog2_min1(RESULT_BYTES);
    localparam int c_wait_w   = clog2_min1(RD_LATENCY);
    localparam int c_cnt_w    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_id_w-1:0]   c_id_last   = c_id_w'(NUM_MACROS - 1);
    localparam logic [c_bidx_w-1:0] c_bidx_last = c_bidx_w'(RESULT_BYTES - 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(RD_LATENCY - 1);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [c_id_w-1:0]            r_sel;
    logic [c_id_w-1:0]            r_rr_ptr;
    logic [c_bidx_w-1:0]          r_byte_idx;
    logic [c_wait_w-1:0]          r_wait;
    logic [c_result_w-1:0]        r_word;
    logic [NUM_MACROS-1:0]        r_served;
    logic                         r_irq;

    logic [NUM_MACROS-1:0]        w_eligible;
    logic [NUM_MACROS-1:0]        w_sel_onehot;
    logic [NUM_MACROS-1:0]        w_served_set;
    logic [c_id_w-1:0]            w_pick;
    logic                         w_pick_valid;
    int                           w_idx;
    logic                         w_active;
    logic                         w_push;
    logic                         w_room;
    logic [c_cnt_w-1:0]           w_fifo_count;
    logic [c_id_w+c_result_w-1:0] w_fifo_head;

    assign w_eligible = DATA_AVAILABLE & ~r_served;
    assign w_room     = (w_fifo_count < c_cnt_w'(FIFO_DEPTH));

    // Descending scan so the nearest eligible macro at/after rr_ptr wins last.
    always_comb begin
        w_pick       = '0;
        w_pick_valid = 1'b0;
        w_idx        = 0;
        for (int k = NUM_MACROS - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_MACROS) w_idx -= NUM_MACROS;
            for (int i = 0; i < NUM_MACROS; i++) begin
                if (i == w_idx && w_eligible[i]) begin
                    w_pick       = c_id_w'(i);
                    w_pick_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MACROS; i++) w_sel_onehot[i] = (r_sel == c_id_w'(i));
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_active        = 1'b0;
        w_push          = 1'b0;
        MACRO_RD_SELECT = '0;
        HASH_ADDR       = '0;
        case (r_state)
            IDLE: if (ENABLE && w_pick_valid && w_room) w_state_nxt = ADDR;
            ADDR: begin
                w_active = 1'b1;
                if (r_wait == c_wait_last) w_state_nxt = CAPT;
            end
            CAPT: begin
                w_active    = 1'b1;
                w_state_nxt = (r_byte_idx == c_bidx_last) ? PUSH : ADDR;
            end
            PUSH: begin
                w_push      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_active) begin
            MACRO_RD_SELECT = w_sel_onehot;
            HASH_ADDR       = RESULT_BASE_ADDR + ADDR_W'(r_byte_idx);
        end
    end

    assign w_served_set = w_push ? w_sel_onehot : '0;

    // A flag seen low drops its mask, so the next rising flag is a new result.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_sel      <= '0;
            r_rr_ptr   <= '0;
            r_byte_idx <= '0;
            r_wait     <= '0;
            r_served   <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_served <= (r_served | w_served_set) & DATA_AVAILABLE;
            r_irq    <= (w_fifo_count != '0);
            case (r_state)
                IDLE: begin
                    r_sel      <= w_pick;
                    r_byte_idx <= '0;
                    r_wait     <= '0;
                end
                ADDR: r_wait <= r_wait + 1'b1;
                CAPT: begin
                    r_wait     <= '0;
                    r_byte_idx <= r_byte_idx + 1'b1;
                end
                PUSH: r_rr_ptr <= (r_sel == c_id_last) ? '0 : r_sel + 1'b1;
                default: r_wait <= '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == CAPT) begin
            for (int b = 0; b < RESULT_BYTES; b++) begin
                if (r_byte_idx == c_bidx_w'(b)) r_word[b*DATA_W +: DATA_W] <= DATA_FROM_HASH;
            end
        end
    end

    decred_result_fifo #(
        .WIDTH (c_id_w + c_result_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .i_wr_en   (w_push),
        .i_wr_data ({r_sel, r_word}),
        .i_rd_en   (RES_READY),
        .o_rd_data (w_fifo_head),
        .o_valid   (RES_VALID),
        .o_count   (w_fifo_count)
    );

    assign RES_DATA     = w_fifo_head[c_result_w-1:0];
    assign RES_MACRO_ID = w_fifo_head[c_result_w +: c_id_w];
    assign FIFO_COUNT   = w_fifo_count;
    assign IRQ_OUT      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_decred_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_decred_result_collector
// Description : Self-checking bench: default instance plus an 8-macro, slow, shallow one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decred_result_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en;

    logic [3:0]  a_da, a_sel;
    logic [5:0]  a_addr;
    logic [7:0]  a_din;
    logic        a_valid, a_ready, a_irq;
    logic [31:0] a_data;
    logic [1:0]  a_id;
    logic [3:0]  a_cnt;

    logic [7:0]  b_da, b_sel;
    logic [5:0]  b_addr;
    logic [7:0]  b_din;
    logic        b_valid, b_ready, b_irq;
    logic [31:0] b_data;
    logic [2:0]  b_id;
    logic [1:0]  b_cnt;

    decred_result_collector u_dut_a (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(en), .DATA_AVAILABLE(a_da),
        .MACRO_RD_SELECT(a_sel), .HASH_ADDR(a_addr), .DATA_FROM_HASH(a_din),
        .RES_VALID(a_valid), .RES_READY(a_ready), .RES_DATA(a_data),
        .RES_MACRO_ID(a_id), .FIFO_COUNT(a_cnt), .IRQ_OUT(a_irq)
    );

    decred_result_collector #(.NUM_MACROS(8), .RD_LATENCY(3), .FIFO_DEPTH(2)) u_dut_b (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(en), .DATA_AVAILABLE(b_da),
        .MACRO_RD_SELECT(b_sel), .HASH_ADDR(b_addr), .DATA_FROM_HASH(b_din),
        .RES_VALID(b_valid), .RES_READY(b_ready), .RES_DATA(b_data),
        .RES_MACRO_ID(b_id), .FIFO_COUNT(b_cnt), .IRQ_OUT(b_irq)
    );

    // Macro m returns 0x11*(k+1)+m-2 for byte k; macro 2 gives 11,22,33,44.
    function automatic logic [7:0] hv(int m, logic [5:0] addr);
        int k;
        k = int'(addr) - 56;
        if (k < 0 || k > 3) return 8'hEE;
        return 8'((k + 1) * 17 + m - 2);
    endfunction

    function automatic int sel_idx(logic [7:0] s);
        int n;
        n = -1;
        if ($countones(s) != 1) return -1;
        for (int i = 0; i < 8; i++) if (s[i]) n = i;
        return n;
    endfunction

    function automatic logic [31:0] exp_word(int m);
        return {hv(m, 6'h3B), hv(m, 6'h3A), hv(m, 6'h39), hv(m, 6'h38)};
    endfunction

    logic [7:0] a_pipe, b_pipe0, b_pipe1, b_pipe2;
    always @(posedge clk) begin
        a_pipe  <= (sel_idx(8'(a_sel)) >= 0) ? hv(sel_idx(8'(a_sel)), a_addr) : 8'hFF;
        b_pipe0 <= (sel_idx(b_sel) >= 0) ? hv(sel_idx(b_sel), b_addr) : 8'hFF;
        b_pipe1 <= b_pipe0;
        b_pipe2 <= b_pipe1;
    end
    assign a_din = a_pipe;
    assign b_din = b_pipe2;

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;
    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic push_a(int m, logic [31:0] d);
        exp_t e;
        e.id = m; e.data = d;
        sb_a.push_back(e);
    endtask

    task automatic push_b(int m);
        exp_t e;
        e.id = m; e.data = exp_word(m);
        sb_b.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && a_valid && a_ready) begin
            check("a_pop_expected", 64'(sb_a.size() != 0), 64'd1);
            if (sb_a.size() != 0) begin
                exp_t e;
                e = sb_a.pop_front();
                check("a_id", 64'(a_id), 64'(e.id));
                check("a_data", 64'(a_data), 64'(e.data));
            end
        end
        if (rst_n && b_valid && b_ready) begin
            check("b_pop_expected", 64'(sb_b.size() != 0), 64'd1);
            if (sb_b.size() != 0) begin
                exp_t e;
                e = sb_b.pop_front();
                check("b_id", 64'(b_id), 64'(e.id));
                check("b_data", 64'(b_data), 64'(e.data));
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_a_cnt(int c, int budget, string name);
        int n;
        n = 0;
        while (int'(a_cnt) != c && n < budget) begin tick(); n++; end
        check(name, 64'(a_cnt), 64'(c));
    endtask

    task automatic wait_b_cnt(int c, int budget, string name);
        int n;
        n = 0;
        while (int'(b_cnt) != c && n < budget) begin tick(); n++; end
        check(name, 64'(b_cnt), 64'(c));
    endtask

    task automatic drain_a();
        a_ready = 1'b1;
        wait_a_cnt(0, 30, "a_drain");
        a_ready = 1'b0;
        check("a_sb_empty", 64'(sb_a.size()), 64'd0);
    endtask

    task automatic drain_b();
        b_ready = 1'b1;
        wait_b_cnt(0, 30, "b_drain");
        b_ready = 1'b0;
        check("b_sb_empty", 64'(sb_b.size()), 64'd0);
    endtask

    typedef struct {
        int          macro;
        logic [31:0] data;
    } vec_t;
    vec_t vecs[4];

    initial begin
        vecs[0].macro = 2; vecs[0].data = 32'h44332211;
        vecs[1].macro = 0; vecs[1].data = 32'h4231200F;
        vecs[2].macro = 1; vecs[2].data = 32'h43322110;
        vecs[3].macro = 3; vecs[3].data = 32'h45342312;

        rst_n = 1'b0; en = 1'b1;
        a_da = '0; b_da = '0; a_ready = 1'b0; b_ready = 1'b0;
        tick(3);
        check("rst_a_sel", 64'(a_sel), 64'd0);
        check("rst_a_addr", 64'(a_addr), 64'd0);
        check("rst_a_valid", 64'(a_valid), 64'd0);
        check("rst_a_cnt", 64'(a_cnt), 64'd0);
        check("rst_a_irq", 64'(a_irq), 64'd0);
        check("rst_b_sel", 64'(b_sel), 64'd0);
        check("rst_b_cnt", 64'(b_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single results, one macro at a time.
        for (int v = 0; v < 4; v++) begin
            int n;
            logic [3:0] first_sel;
            n = 0; first_sel = '0;
            a_da[vecs[v].macro] = 1'b1;
            push_a(vecs[v].macro, vecs[v].data);
            while (!a_valid && n < 40) begin
                tick(); n++;
                if (first_sel == '0) first_sel = a_sel;
            end
            check("a_latency", 64'(n), 64'd10);
            check("a_select", 64'(first_sel), 64'd1 << vecs[v].macro);
            check("a_irq_lag", 64'(a_irq), 64'd0);
            tick();
            check("a_irq", 64'(a_irq), 64'd1);
            a_ready = 1'b1; tick(); a_ready = 1'b0;
            a_da = '0;
            tick(2);
        end

        // Round robin.
        a_da = 4'b1001; push_a(0, exp_word(0)); push_a(3, exp_word(3));
        wait_a_cnt(2, 60, "a_rr_cnt2");
        a_da = '0; tick(2);
        a_da = 4'b1001; push_a(0, exp_word(0)); push_a(3, exp_word(3));
        wait_a_cnt(4, 60, "a_rr_cnt4");
        a_da = '0; tick(2);
        a_da = 4'b0001; push_a(0, exp_word(0));
        wait_a_cnt(5, 40, "a_rr_cnt5");
        a_da = '0; tick(2);
        a_da = 4'b1001; push_a(3, exp_word(3)); push_a(0, exp_word(0));
        wait_a_cnt(7, 60, "a_rr_cnt7");
        a_da = '0;
        drain_a();

        // Held flag captured once; a one-cycle drop rearms it.
        a_da = 4'b0010; push_a(1, exp_word(1));
        tick(100);
        check("a_rearm_once", 64'(a_cnt), 64'd1);
        a_da = '0; tick();
        a_da = 4'b0010; push_a(1, exp_word(1));
        wait_a_cnt(2, 40, "a_rearm_twice");
        a_da = '0;
        drain_a();

        // ENABLE dropped mid-capture.
        begin
            int n;
            n = 0;
            a_da = 4'b0010; push_a(1, exp_word(1));
            while (a_sel == '0 && n < 10) begin tick(); n++; end
            check("a_en_started", 64'(a_sel), 64'd2);
            en = 1'b0; a_da[3] = 1'b1;
            tick(40);
            check("a_en_cnt", 64'(a_cnt), 64'd1);
            en = 1'b1; push_a(3, exp_word(3));
            wait_a_cnt(2, 40, "a_en_resume");
            a_da = '0;
            drain_a();
        end

        // Reset during byte 2 of a capture.
        begin
            int n;
            n = 0;
            a_da = 4'b0001; push_a(0, exp_word(0));
            wait_a_cnt(1, 40, "a_pre_rst");
            a_da = 4'b0101;
            while (a_addr != 6'h3A && n < 30) begin tick(); n++; end
            check("a_rst_byte2", 64'(a_sel), 64'd4);
            rst_n = 1'b0;
            tick();
            check("a_rst_sel", 64'(a_sel), 64'd0);
            check("a_rst_cnt", 64'(a_cnt), 64'd0);
            check("a_rst_irq", 64'(a_irq), 64'd0);
            check("a_rst_valid", 64'(a_valid), 64'd0);
            sb_a.delete(); sb_b.delete();
            rst_n = 1'b1;
            push_a(0, exp_word(0)); push_a(2, exp_word(2));
            wait_a_cnt(2, 60, "a_after_rst");
            a_da = '0;
            drain_a();
        end

        // Slow instance: each address held RD_LATENCY cycles plus the capture cycle.
        begin
            int n, held;
            n = 0; held = 0;
            b_da = 8'h80; push_b(7);
            while (!b_valid && n < 60) begin
                tick(); n++;
                if (b_addr == 6'h38 && b_sel != '0) held++;
            end
            check("b_latency", 64'(n), 64'd18);
            check("b_addr_hold", 64'(held), 64'd4);
            b_ready = 1'b1; tick(); b_ready = 1'b0;
            b_da = '0; tick(2);
        end

        // Full FIFO stalls new captures without dropping flags.
        begin
            int stray;
            stray = 0;
            b_da = 8'hE0; push_b(5); push_b(6); push_b(7);
            wait_b_cnt(2, 60, "b_full");
            repeat (30) begin
                tick();
                if (b_sel != '0) stray++;
            end
            check("b_stall_sel", 64'(stray), 64'd0);
            check("b_stall_cnt", 64'(b_cnt), 64'd2);
            b_ready = 1'b1; tick(); b_ready = 1'b0;
            check("b_after_pop", 64'(b_cnt), 64'd1);
            wait_b_cnt(2, 40, "b_third");
            b_da = '0;
            drain_b();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
